sobel_window_buffer: RTL
========================

// Module: sobel_window_buffer
// PURPOSE
//  Upstream neighbour of sobel_core. Turns a raster pixel stream (one pixel/beat, valid/ready)
//  into 3x3 sobel_matrix windows, using two line buffers plus a 3x3 shift window.
//  Emits only fully-populated windows (no border padding): (IMG_WIDTH-2)*(IMG_HEIGHT-2) per frame.
//  Its output register feeds sobel_core combinationally. PIXEL_WIDTH and sobel_matrix come from sobel_control.svh.
// PARAMETERS
//  IMG_WIDTH   640  pixels per line (>=3); sizes both line buffers and the column counter
//  IMG_HEIGHT  480  lines per frame (>=3); sizes the row counter
// PORTS
//  clk_i          in   1            clock, rising edge
//  nreset_i       in   1            asynchronous active-low reset
//  pix_i          in   PIXEL_WIDTH  input pixel, raster order
//  pix_valid_i    in   1            pix_i valid
//  pix_sof_i      in   1            qualifies pix_i as pixel (0,0) of a frame
//  pix_ready_o    out  1            block can accept pix_i this cycle
//  win_o          out  sobel_matrix 3x3 window: vector0=top row, vector2=bottom row; pix0=left, pix2=right
//  win_valid_o    out  1            win_o valid
//  win_eof_o      out  1            win_o is the last window of the frame
//  win_ready_i    in   1            downstream accepts win_o
//  frame_err_o    out  1            1-cycle pulse: pixel arrived in IDLE without pix_sof_i (pixel dropped)
// BEHAVIOUR
//  - Reset: state IDLE; col/row counters 0; win_o, win_valid_o, win_eof_o, frame_err_o all 0; pix_ready_o 1.
//    Line-buffer RAM is not reset; its contents are don't-care until overwritten during FILL.
//  - Accept = pix_valid_i & pix_ready_o; pix_ready_o = ~win_valid_o | win_ready_i (single-stage skid, no bubble).
//  - Output hold: while win_valid_o & ~win_ready_i, win_o and win_eof_o hold stable.
//  - FSM: IDLE -> FILL on an accept with pix_sof_i. FILL -> RUN on the accept that completes row 1.
//    RUN -> IDLE on the accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
//    An accept with pix_sof_i in any state restarts the frame: counters -> (0,0), state -> FILL.
//    The restart does not drop an already-registered window.
//  - IDLE accept without pix_sof_i: pixel discarded, frame_err_o=1 next cycle, state stays IDLE.
//  - Per accept at (r,c): new column = {lb_top[c], lb_mid[c], pix_i}; lb_top[c] <= lb_mid[c]; lb_mid[c] <= pix_i.
//    Window shifts left (pix0<=pix1, pix1<=pix2, pix2<=new column) per row vector.
//  - Counters: c increments per accept and wraps to 0 at IMG_WIDTH-1, which increments r.
//    r wraps to 0 after IMG_HEIGHT-1.
//  - Emit: if r>=2 and c>=2 at the accept, win_valid_o=1 on the next cycle (latency 1 clk).
//    The emitted window is centred on (r-1,c-1). Columns 0..1 of each row refill the window and emit nothing.
//  - win_eof_o=1 with the window produced by the accept of (IMG_HEIGHT-1, IMG_WIDTH-1).
//  - win_valid_o clears after a handshake unless a new window is produced in the same cycle.
//  - Widths: counters $clog2(IMG_WIDTH) / $clog2(IMG_HEIGHT) bits. Pixels pass unmodified; no arithmetic on data.
//  - Reset mid-frame: all state cleared immediately (async); the next frame requires pix_sof_i.
// TESTING (IMG_WIDTH=5, IMG_HEIGHT=4, pix=10*r+c, win_ready_i=1 unless stated)
//  1 Full ramp frame, sof on (0,0) -> 6 windows. First window arrives 1 clk after accepting (2,2):
//    vector0={0,1,2}, vector1={10,11,12}, vector2={20,21,22}.
//    Last window: vector2={32,33,34}, win_eof_o=1. FSM ends in IDLE.
//  2 win_ready_i low for 3 cycles after the first window -> win_o stays {0,1,2/...}, pix_ready_o=0;
//    the stream resumes with no lost or duplicated window (still 6 total).
//  3 Two back-to-back frames, second pix_sof_i on the cycle after the first frame's last pixel ->
//    12 windows total, win_eof_o exactly twice.
//  4 pix_valid_i=1 with pix_sof_i=0 after reset -> frame_err_o pulses once per pixel; zero windows; state IDLE.
//  5 pix_sof_i reasserted at (2,1) of frame A, then a full frame B with pix=100+10*r+c ->
//    the first window after restart is {100,101,102 / 110,111,112 / 120,121,122}.
//  6 nreset_i pulsed low at (2,3) mid-frame -> win_valid_o=0 immediately, pix_ready_o=1;
//    the next sof frame behaves as in test 1.

Source files
------------

// File: rtl/sobel_window_buffer.sv
// -----------------------------------------------------------------------------
// sobel_window_pkg / sobel_window_buffer
//
// Purpose
//   Converts a raster pixel stream (one pixel per beat, valid/ready) into 3x3
//   windows for the downstream Sobel core. Two line buffers hold the previous
//   two image rows. A 3x3 shift window gathers one new column per accepted
//   pixel. Only fully populated windows are emitted, so each frame produces
//   (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows. Border pixels are never padded.
//   The window register drives win_o directly, so the Sobel core sees a
//   registered matrix.
//
// Ports
//   clk_i        in   clock, rising edge
//   nreset_i     in   asynchronous active-low reset
//   pix_i        in   input pixel, raster order
//   pix_valid_i  in   pix_i valid
//   pix_sof_i    in   pix_i is pixel (0,0) of a frame
//   pix_ready_o  out  block can accept pix_i this cycle
//   win_o        out  3x3 window: vector0 = top row, vector2 = bottom row;
//                     pix0 = left column, pix2 = right column
//   win_valid_o  out  win_o valid
//   win_eof_o    out  win_o is the last window of the frame
//   win_ready_i  in   downstream accepts win_o
//   frame_err_o  out  1-cycle pulse: pixel seen in IDLE without pix_sof_i
//                     (the pixel is dropped)
// -----------------------------------------------------------------------------

package sobel_window_pkg;

    localparam int PIXEL_WIDTH = 8;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    // One window row, left to right.
    typedef struct packed {
        pixel_t pix0;
        pixel_t pix1;
        pixel_t pix2;
    } sobel_vector;

    // Full window, top to bottom.
    typedef struct packed {
        sobel_vector vector0;
        sobel_vector vector1;
        sobel_vector vector2;
    } sobel_matrix;

    typedef enum logic [1:0] {
        ST_IDLE,   // waiting for a start-of-frame pixel
        ST_FILL,   // rows 0 and 1: line buffers are filling, no windows yet
        ST_RUN     // rows 2 and later: windows are produced
    } win_state_e;

endpackage

module sobel_window_buffer
    import sobel_window_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic [PIXEL_WIDTH-1:0] pix_i,
    input  logic                   pix_valid_i,
    input  logic                   pix_sof_i,
    output logic                   pix_ready_o,
    output sobel_matrix            win_o,
    output logic                   win_valid_o,
    output logic                   win_eof_o,
    input  logic                   win_ready_i,
    output logic                   frame_err_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    win_state_e    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    sobel_matrix   win_q, win_d;
    logic          win_valid_q, win_valid_d;
    logic          win_eof_q, win_eof_d;
    logic          frame_err_q, frame_err_d;

    // Line buffers: lb_top holds row r-2 and lb_mid holds row r-1 at each column.
    pixel_t lb_top_mem [IMG_WIDTH];
    pixel_t lb_mid_mem [IMG_WIDTH];

    // ------------------------------------------------------------------
    // Handshake and position decode
    // ------------------------------------------------------------------
    logic          accept;
    logic          process;
    logic [CW-1:0] pos_c;
    logic [RW-1:0] pos_r;
    logic          at_row_end;
    logic          at_last;
    logic          emit;
    pixel_t        lb_top_rd;
    pixel_t        lb_mid_rd;

    // A single output stage: new input is taken whenever the output stage
    // is empty or is being drained in this same cycle.
    assign pix_ready_o = ~win_valid_q | win_ready_i;
    assign accept      = pix_valid_i & pix_ready_o;

    // An accepted pixel is used whenever it starts a frame or a frame is
    // already in progress. Only an IDLE pixel without SOF is dropped.
    assign process = accept & (pix_sof_i | (state_q != ST_IDLE));

    // SOF forces the pixel to (0,0), whatever the counters hold, so a
    // restart mid-frame is treated exactly like the first pixel of a frame.
    assign pos_c = pix_sof_i ? '0 : col_q;
    assign pos_r = pix_sof_i ? '0 : row_q;

    assign at_row_end = (pos_c == COL_LAST);
    assign at_last    = at_row_end & (pos_r == ROW_LAST);
    assign emit       = process & (pos_r >= ROW_TWO) & (pos_c >= COL_TWO);

    assign lb_top_rd = lb_top_mem[pos_c];
    assign lb_mid_rd = lb_mid_mem[pos_c];

    // NOTE: line-buffer RAM has no reset. Every entry is written during rows 0
    //       and 1 of each frame before any window reads it, and leaving it
    //       unreset lets it map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (process) begin
            lb_top_mem[pos_c] <= lb_mid_rd;
            lb_mid_mem[pos_c] <= pix_i;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every *_d gets a default at the top of the block. The branches
    //       below only override it, so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        // A stalled window keeps valid and eof. A drained window clears them.
        win_valid_d = win_valid_q & ~win_ready_i;
        win_eof_d   = (win_valid_q & ~win_ready_i) ? win_eof_q : 1'b0;
        frame_err_d = accept & ~pix_sof_i & (state_q == ST_IDLE);

        if (process) begin
            // Shift every row left by one and insert the new column at the right.
            win_d.vector0.pix0 = win_q.vector0.pix1;
            win_d.vector0.pix1 = win_q.vector0.pix2;
            win_d.vector0.pix2 = lb_top_rd;
            win_d.vector1.pix0 = win_q.vector1.pix1;
            win_d.vector1.pix1 = win_q.vector1.pix2;
            win_d.vector1.pix2 = lb_mid_rd;
            win_d.vector2.pix0 = win_q.vector2.pix1;
            win_d.vector2.pix1 = win_q.vector2.pix2;
            win_d.vector2.pix2 = pix_i;

            // Raster counters advance from the pixel's effective position.
            if (at_row_end) begin
                col_d = '0;
                row_d = (pos_r == ROW_LAST) ? '0 : pos_r + ROW_ONE;
            end else begin
                col_d = pos_c + CW'(1);
                row_d = pos_r;
            end

            if (at_last) begin
                state_d = ST_IDLE;
            end else if (at_row_end && (pos_r == ROW_ONE)) begin
                state_d = ST_RUN;
            end else if (pix_sof_i) begin
                state_d = ST_FILL;
            end

            if (emit) begin
                win_valid_d = 1'b1;
                win_eof_d   = at_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: state updates use non-blocking assignments, so every flop samples
    //       the pre-edge values no matter what order the statements run in.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_eof_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            win_eof_q   <= win_eof_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign win_o       = win_q;
    assign win_valid_o = win_valid_q;
    assign win_eof_o   = win_eof_q;
    assign frame_err_o = frame_err_q;

endmodule
